// File: rtl/nbit_serial_addsub.sv
// nbit_serial_addsub: slice-serial N-bit adder/subtractor with a valid/ready
// handshake on both sides. The operation takes N/K cycles, one K-bit slice
// per cycle, LSB slice first.
// Optional feature: define NBIT_ADDSUB_SAT_EN for signed saturation on overflow.
module nbit_serial_addsub #(
    parameter int unsigned N = 32,
    parameter int unsigned K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cry_flag,
    output logic         zr_flag,
    output logic         of_flag,
    output logic         neg_flag
);

    localparam int unsigned NS = N / K;
    localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic           r_op;
    logic           r_a_msb;
    logic           r_b_msb;
    logic           r_carry;
    logic           r_zero;
    logic [CW-1:0]  r_cnt;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [N-1:0]   r_result;
    logic           r_cry;
    logic           r_zr;
    logic           r_of;
    logic           r_neg;

    logic [K-1:0]   w_b_sl;
    logic [K:0]     w_sum;
    logic [K-1:0]   w_sum_sl;
    logic [N-1:0]   w_next_acc;
    logic [N-1:0]   w_final;
    logic           w_of;
    logic           w_zr;
    logic           w_last;

    // Current slice sum; operand registers are shifted so the active slice is always at the bottom
    always_comb begin
        w_b_sl   = r_op ? ~r_b[K-1:0] : r_b[K-1:0];
        w_sum    = {1'b0, r_a[K-1:0]} + {1'b0, w_b_sl} + (K+1)'(r_carry);
        w_sum_sl = w_sum[K-1:0];
        w_last   = (r_cnt == CW'(NS - 1));
    end

    // Partial-result accumulator: completed slices shift in from the top
    if (NS == 1) begin : g_one
        assign w_next_acc = w_sum_sl;
    end else begin : g_multi
        logic [N-K-1:0] r_acc;

        assign w_next_acc = {w_sum_sl, r_acc};

        // Keep the upper N-K bits of the result built so far
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (r_state == RUN) begin
                r_acc <= w_next_acc[N-1:K];
            end
        end
    end

    // Overflow and final output value, with optional signed saturation
    always_comb begin
        w_of = (r_op ? (r_a_msb != r_b_msb) : (r_a_msb == r_b_msb))
               && (w_next_acc[N-1] != r_a_msb);
`ifdef NBIT_ADDSUB_SAT_EN
        if (w_of) begin
            w_final = r_a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            w_final = w_next_acc;
        end
        w_zr = !w_of && r_zero && (w_sum_sl == '0);
`else
        w_final = w_next_acc;
        w_zr    = r_zero && (w_sum_sl == '0);
`endif
    end

    // Control FSM, operand capture, slice sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cry       <= 1'b0;
            r_zr        <= 1'b0;
            r_of        <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= op;
                        r_a_msb    <= a[N-1];
                        r_b_msb    <= b[N-1];
                        r_carry    <= op;
                        r_zero     <= 1'b1;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> K;
                    r_b     <= r_b >> K;
                    r_carry <= w_sum[K];
                    r_zero  <= r_zero && (w_sum_sl == '0);
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_result    <= w_final;
                        r_cry       <= w_sum[K];
                        r_of        <= w_of;
                        r_zr        <= w_zr;
                        r_neg       <= w_final[N-1];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cry_flag  = r_cry;
    assign zr_flag   = r_zr;
    assign of_flag   = r_of;
    assign neg_flag  = r_neg;

endmodule
